// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB-first, stop bit, valid/ready output.
// Optional even-parity bit between data and stop when SERIAL_FRAME_RX_PARITY_EN is defined.
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
`ifdef SERIAL_FRAME_RX_PARITY_EN
  output logic             overrun,
  output logic             parity_err
`else
  output logic             overrun
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             par_bad;
  logic             word_ok, load, drop, stop_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (!si) state_nxt = DATA;
      DATA: begin
        if (cnt == LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A good word either loads (output free or being consumed this edge) or is dropped.
  always_comb begin
    busy     = (state != IDLE);
    stop_bad = (state == STOP) && !si;
    word_ok  = (state == STOP) && si && !par_bad;
    load     = word_ok && (!valid || ready);
    drop     = word_ok && valid && !ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == DATA) begin
      sh  <= {sh[WIDTH-2:0], si};
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        data_out <= sh;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid    <= 1'b0;
      end
      frame_err <= stop_bad | (frame_err & ~clr_err);
      overrun   <= drop | (overrun & ~clr_err);
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_set;

  // Even parity: XOR over data bits and the parity bit must be zero.
  always_comb par_set = (state == PARITY) && ((^sh) ^ si);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY) par_bad <= par_set;
      parity_err <= par_set | (parity_err & ~clr_err);
    end
  end
`else
  assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (WIDTH=8): vector table, directed corner cases, random vs model.
module tb_serial_frame_rx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         si = 1'b1;
  logic         ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] data_out;
  logic         valid, busy, frame_err, overrun;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic         parity_err;
`endif

  serial_frame_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .si(si), .ready(ready), .clr_err(clr_err),
    .data_out(data_out), .valid(valid), .busy(busy),
    .frame_err(frame_err),
`ifdef SERIAL_FRAME_RX_PARITY_EN
    .overrun(overrun), .parity_err(parity_err)
`else
    .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position counter plus arithmetic word assembly.
  int           m_pos = -1;
  logic [W-1:0] m_word = '0, m_data = '0;
  bit           m_valid = 0, m_ferr = 0, m_ovr = 0, m_pbad = 0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  bit           m_perr = 0;
`endif

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_pos = -1; m_word = '0; m_data = '0; m_valid = 0;
    m_ferr = 0; m_ovr = 0; m_pbad = 0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    m_perr = 0;
`endif
  endfunction

  function automatic void model_edge(input bit s, input bit r, input bit c);
    bit load = 0, fe = 0, ov = 0, pe = 0;
    if (m_pos < 0) begin
      if (!s) begin m_pos = 0; m_word = '0; end
    end else if (m_pos < W) begin
      m_word = W'((m_word * 2) + s);
      m_pos++;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    end else if (m_pos == W) begin
      m_pbad = ((($countones(m_word) + s) % 2) != 0);
      pe = m_pbad;
      m_pos++;
`endif
    end else begin
      if (!s) fe = 1;
      else if (!m_pbad) begin
        if (!m_valid || r) load = 1;
        else ov = 1;
      end
      m_pos = -1;
      m_pbad = 0;
    end
    if (load) begin m_valid = 1; m_data = m_word; end
    else if (m_valid && r) m_valid = 0;
    m_ferr = fe || (m_ferr && !c);
    m_ovr  = ov || (m_ovr && !c);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    m_perr = pe || (m_perr && !c);
`else
    if (pe) m_ovr = m_ovr;
`endif
  endfunction

  task automatic cmp_model();
    chk("valid", valid, m_valid);
    chk("data_out", data_out, m_data);
    chk("busy", busy, (m_pos >= 0));
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    chk("parity_err", parity_err, m_perr);
`endif
  endtask

  task automatic cyc(input bit s, input bit r, input bit c);
    si = s; ready = r; clr_err = c;
    @(posedge clk);
    model_edge(s, r, c);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit stopb, input bit r, input bit c_stop);
    cyc(1'b0, r, 1'b0);
    for (int i = W - 1; i >= 0; i--) cyc(d[i], r, 1'b0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    cyc(^d, r, 1'b0);
`endif
    cyc(stopb, r, c_stop);
  endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
  task automatic send_frame_par(input logic [W-1:0] d, input bit pbit, input bit r);
    cyc(1'b0, r, 1'b0);
    for (int i = W - 1; i >= 0; i--) cyc(d[i], r, 1'b0);
    cyc(pbit, r, 1'b0);
    cyc(1'b1, r, 1'b0);
  endtask
`endif

  typedef struct {
    logic [W-1:0] d;
    bit           stopb;
    bit           r;
    bit           ev;
    logic [W-1:0] ed;
    bit           efe;
  } vec_t;

  vec_t tv[5];

  initial begin
    tv[0] = '{d: 8'hA5, stopb: 1, r: 1, ev: 1, ed: 8'hA5, efe: 0};
    tv[1] = '{d: 8'h55, stopb: 0, r: 1, ev: 0, ed: 8'h00, efe: 1};
    tv[2] = '{d: 8'h3C, stopb: 1, r: 0, ev: 1, ed: 8'h3C, efe: 0};
    tv[3] = '{d: 8'h00, stopb: 1, r: 1, ev: 1, ed: 8'h00, efe: 0};
    tv[4] = '{d: 8'hFF, stopb: 0, r: 0, ev: 0, ed: 8'h00, efe: 1};

    #1;
    model_reset();
    chk("init_valid", valid, 0);
    chk("init_data", data_out, 0);
    chk("init_busy", busy, 0);
    chk("init_ferr", frame_err, 0);
    chk("init_ovr", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 1, 0);

    for (int k = 0; k < 5; k++) begin
      do_reset();
      send_frame(tv[k].d, tv[k].stopb, tv[k].r, 1'b0);
      chk("tv_valid", valid, tv[k].ev);
      chk("tv_data", data_out, tv[k].ed);
      chk("tv_ferr", frame_err, tv[k].efe);
      chk("tv_ovr", overrun, 0);
      chk("tv_busy", busy, 0);
    end

    // Single A5 with ready high: valid lasts exactly one cycle.
    do_reset();
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("a5_busy_e0", busy, 1);
    for (int i = W - 1; i >= 0; i--) cyc(((8'hA5 >> i) & 1) != 0, 1, 0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    cyc(0, 1, 0);
`endif
    chk("a5_busy_last", busy, 1);
    chk("a5_valid_pre", valid, 0);
    cyc(1, 1, 0);
    chk("a5_valid", valid, 1);
    chk("a5_data", data_out, 8'hA5);
    cyc(1, 1, 0);
    chk("a5_valid_drop", valid, 0);

    // Back-to-back with ready low: second word dropped, overrun set.
    do_reset();
    send_frame(8'h3C, 1, 0, 0);
    send_frame(8'hC3, 1, 0, 0);
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data_out, 8'h3C);
    chk("ovr_flag", overrun, 1);
    cyc(1, 1, 0);
    chk("ovr_consumed", valid, 0);
    chk("ovr_data_hold", data_out, 8'h3C);
    cyc(1, 1, 1);
    chk("ovr_clr", overrun, 0);

    // Frame error, clear, then a good frame.
    do_reset();
    send_frame(8'h55, 0, 1, 0);
    chk("fe_set", frame_err, 1);
    chk("fe_valid", valid, 0);
    cyc(1, 1, 1);
    chk("fe_clr", frame_err, 0);
    send_frame(8'h55, 1, 1, 0);
    chk("fe_good_valid", valid, 1);
    chk("fe_good_data", data_out, 8'h55);
    // Error event coincident with clr_err: the set wins.
    send_frame(8'hAA, 0, 1, 1);
    chk("fe_setwins", frame_err, 1);

    // Reset during data bit 4 of 0xF0.
    do_reset();
    cyc(0, 1, 0);
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    si = 1'b1;
    do_reset();
    chk("midrst_busy", busy, 0);
    send_frame(8'h81, 1, 1, 0);
    chk("midrst_valid", valid, 1);
    chk("midrst_data", data_out, 8'h81);
    chk("midrst_ferr", frame_err, 0);

    // Back-to-back with ready high.
    do_reset();
    send_frame(8'h01, 1, 1, 0);
    chk("b2b_v1", valid, 1);
    chk("b2b_d1", data_out, 8'h01);
    send_frame(8'hFF, 1, 1, 0);
    chk("b2b_v2", valid, 1);
    chk("b2b_d2", data_out, 8'hFF);
    chk("b2b_ovr", overrun, 0);
    chk("b2b_ferr", frame_err, 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    do_reset();
    send_frame_par(8'h07, 0, 1);
    chk("par_err", parity_err, 1);
    chk("par_valid", valid, 0);
    send_frame_par(8'h07, 1, 1);
    chk("par_ok_valid", valid, 1);
    chk("par_ok_data", data_out, 8'h07);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial-to-parallel frame receiver, the receive end of the team's serial bit link.
- Samples one line bit per clock and detects a start bit.
- Shifts in WIDTH data bits MSB-first and checks the stop bit.
- Presents the assembled word on a valid/ready parallel interface, with sticky error flags for the control logic.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- si  input  1  serial line; idles high, one bit per clock.
- ready  input  1  consumer accepts data_out when ready and valid are both high at a posedge.
- clr_err  input  1  single-cycle pulse clearing the sticky error flags.
- data_out  output  WIDTH  last good received word; registered.
- valid  output  1  data_out holds an unconsumed word.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- frame_err  output  1  sticky: a frame ended with stop bit 0.
- overrun  output  1  sticky: a good frame was dropped because the output was still occupied.

Behaviour:
- Reset (asynchronous, any cycle, including mid-frame):
  - state=IDLE; shift register, bit counter, data_out, valid, busy, frame_err and overrun all 0.
  - Any partial frame is discarded.
- Frame format: start bit 0, then WIDTH data bits MSB-first, then stop bit 1.
- Edge numbering: the start bit is sampled at edge e0, data at e1..eWIDTH, stop at eWIDTH+1.
- FSM: IDLE -> DATA -> STOP -> IDLE.
  - IDLE: si=1 holds IDLE. si=0 at a posedge -> DATA; counter cleared.
  - DATA: each posedge shifts sh <= {sh[WIDTH-2:0], si} and increments the counter. After the WIDTH-th bit -> STOP.
  - STOP: samples si and always returns to IDLE.
- STOP with si=1, output free (valid=0, or valid&&ready at this edge): data_out<=sh, valid<=1.
  - Latency: valid rises on the stop-sampling edge eWIDTH+1.
- STOP with si=1, output occupied (valid=1 and ready=0): word dropped, overrun<=1, data_out unchanged.
- STOP with si=0: word discarded, frame_err<=1, valid/data_out unchanged.
- Handshake:
  - valid holds and data_out stays stable until valid&&ready at a posedge.
  - valid then clears, unless a new word loads on the same edge; in that case valid stays 1 and data_out takes the new word.
- Back-to-back frames: a new start bit may be sampled at eWIDTH+2; no idle gap is required.
- A 0 sampled on the line in IDLE is always a start bit; there is no glitch filtering.
- Sticky flags: clr_err clears frame_err and overrun at the next posedge. If an error event occurs on the same edge as clr_err, the set wins.
- busy is decoded combinationally from state: 1 in DATA/STOP, 0 in IDLE.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit (XOR of the data bits and the parity bit must be 0).
  - Output port parity_err (1 bit, sticky, cleared by clr_err, set wins) is added.
  - A parity mismatch sets parity_err; the word is discarded and the stop bit is still consumed.
  - The stop bit is sampled at eWIDTH+2, so valid rises one edge later than without the macro.
- When not defined: no PARITY state, no parity_err port; frame timing is exactly as described above.

Test Plan:
- WIDTH=8, ready=1, line idle high. Send start 0, bits 1,0,1,0,0,1,0,1, stop 1 -> data_out=8'hA5, valid=1 for exactly one cycle starting at e9; frame_err=0, overrun=0; busy=1 from e0 to e8.
- ready=0. Send 0x3C then 0xC3 back-to-back -> valid stays 1, data_out=0x3C, overrun=1 at e19. Raise ready -> valid falls on that edge with 0x3C consumed; 0xC3 is never presented.
- Send 0x55 with stop bit 0 -> frame_err=1, valid stays 0. Pulse clr_err -> frame_err=0 next edge. A following good 0x55 frame -> valid with 0x55.
- Assert rst during data bit 4 of frame 0xF0 -> all outputs 0 immediately, FSM in IDLE. Next frame 0x81 -> data_out=0x81, valid=1, no errors.
- ready=1. Send frames 0x01 and 0xFF with no gap -> valid pulses at e9 (0x01) and e19 (0xFF); no errors.
- SERIAL_FRAME_RX_PARITY_EN defined: send 0x07 with parity bit 0 -> parity_err=1, valid stays 0. Resend with parity bit 1 -> data_out=0x07, valid=1 at e10.
